audio_adc_deserializer: RTL and testbench
=========================================

# audio_adc_deserializer

Receive-side counterpart of the audio DAC path: deserializes I2S ADC data from the codec (ADCDAT, BCLK, ADCLRCK), assembles stereo sample pairs, and buffers them in a FIFO behind a valid/ready stream toward the Nios II/Avalon side. The codec is bus master; all codec pins are asynchronous to the system clock and are oversampled in the clk_clk domain.

## Interface
- DATA_WIDTH, 24: bits per channel sample, MSB-first.
- FIFO_DEPTH, 16: stereo pairs buffered; power of two, ≥ 2.
- clk_clk  in  1  system clock; must be ≥ 8× BCLK.
- reset_reset_n  in  1  reset: **asynchronous, active-low**; one clock domain only.
- enable  in  1  1 = capture; 0 = state machine held in IDLE, FIFO contents kept.
- clear  in  1  synchronous: flush FIFO, clear overflow.
- adc_bclk  in  1  codec bit clock (async).
- adc_lrck  in  1  codec L/R clock (async); 0 = left, 1 = right.
- adc_dat  in  1  codec serial data (async).
- sample_valid  out  1  FIFO head valid.
- sample_ready  in  1  consumer accepts head when valid & ready.
- sample_left  out  DATA_WIDTH  head left sample.
- sample_right  out  DATA_WIDTH  head right sample.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries stored.
- overflow  out  1  sticky: a pair was dropped because FIFO was full.

## Operation
- adc_bclk, adc_lrck, adc_dat each pass a 2-flop synchronizer; a third flop on bclk yields bclk_rise (one-cycle pulse).
- All capture happens on bclk_rise only; lrck and dat are sampled in the same cycle as bclk_rise.
- lrck_prev holds lrck from the previous bclk_rise; an lrck change at a bclk_rise marks the I2S delay slot (that bit is discarded); bit counter resets to 0.
- On subsequent bclk_rise: if bit_cnt < DATA_WIDTH shift dat into shift register at LSB, bit_cnt++; further bits ignored. Short words zero-filled at LSBs on completion.
- States: IDLE → (lrck 1→0 seen) LEFT → (lrck 0→1) latch left word, RIGHT → (lrck 1→0) latch right word, push pair, LEFT.
- IDLE discards any partial frame after reset, enable rising, or clear.
- Push when FIFO full: pair dropped, overflow ← 1; FIFO contents unchanged.
- Push and pop in the same cycle at full: pop first, push accepted; at empty: push accepted, valid next cycle.
- clear has priority over push/pop that cycle; state machine returns to IDLE.
- enable = 0 mid-word: word discarded, IDLE.

## Timing
- Reset values: sample_valid 0, sample_left/right 0, fifo_level 0, overflow 0, state IDLE, counters 0.
- Pin to bclk_rise latency: 3 clk.
- Push: pair written the cycle after bclk_rise that detects lrck 1→0; sample_valid rises one cycle later (first-word-fall-through, registered outputs).
- Pop: head advances cycle after valid & ready; back-to-back pops at one per clock.
- fifo_level updates the cycle after push/pop.
- Wrap-around: read/write pointers one bit wider than address; full = MSBs differ, addresses equal.

## Structure
- Package audio_adc_pkg: DATA_WIDTH default, state enum (IDLE/LEFT/RIGHT), stereo-pair struct {left, right}.
- Sub-module audio_sample_fifo: synchronous FIFO of stereo pairs with level/full/empty; deserializer core stays in top.

## Test plan
- I2S frames at BCLK = clk/16, left 0xABCDEF, right 0x123456 -> after second LRCK falling edge, pair (0xABCDEF, 0x123456) valid, level 1.
- Reset de-asserted mid right word -> that frame discarded; first pushed pair is the next complete frame.
- 17 frames, sample_ready = 0, depth 16 -> level 16, overflow 1, popped pairs are frames 1–16 in order.
- 16-bit frames (LRCK toggles after 17 BCLKs), DATA_WIDTH 24, left 0x8001 -> sample_left 0x800100.
- Full FIFO, push and pop same cycle -> level stays 16, overflow stays 0, new pair at tail.
- clear asserted with level 5 and overflow 1 -> level 0, overflow 0, sample_valid 0 next cycle; capture resumes after next LRCK falling edge.

Source files
------------

// File: rtl/audio_adc_deserializer_pkg.sv
// rtl/audio_adc_deserializer_pkg.sv - shared types and defaults for the I2S ADC receive path
package audio_adc_pkg;

    localparam int ADC_DATA_WIDTH = 24;
    localparam int ADC_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADC_DATA_WIDTH-1:0] left;
        logic [ADC_DATA_WIDTH-1:0] right;
    } stereo_pair_t;

endpackage

// File: rtl/audio_adc_deserializer_if.sv
// rtl/audio_adc_deserializer_if.sv - stereo sample stream from the deserializer FIFO head
interface audio_adc_deserializer_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  sample_valid;
    logic                  sample_ready;
    logic [DATA_WIDTH-1:0] sample_left;
    logic [DATA_WIDTH-1:0] sample_right;

    modport master (
        output sample_valid,
        output sample_left,
        output sample_right,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_left,
        input  sample_right,
        output sample_ready
    );
endinterface

// File: rtl/audio_adc_deserializer_fifo.sv
// rtl/audio_adc_deserializer_fifo.sv - first-word-fall-through FIFO of stereo pairs, registered head
module audio_sample_fifo
    import audio_adc_pkg::*;
#(
    parameter type pair_t = stereo_pair_t,
    parameter int  DEPTH  = ADC_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  pair_t                  push_data,
    input  logic                   pop_ready,
    output logic                   head_valid,
    output pair_t                  head_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   drop
);
    localparam int AW = $clog2(DEPTH);

    pair_t       mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic        full, do_pop, do_push;
    pair_t       head_n;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign do_pop   = head_valid & pop_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push  = push & (~full | do_pop);
    assign drop     = push & full & ~do_pop;
    assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, do_pop};
    assign wr_ptr_n = wr_ptr + {{AW{1'b0}}, do_push};

    // Next head bypasses memory when it is the entry being written this cycle.
    always_comb begin
        head_n = '0;
        if (wr_ptr_n != rd_ptr_n) begin
            if (do_push && (rd_ptr_n == wr_ptr))
                head_n = push_data;
            else
                head_n = mem[rd_ptr_n[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            head_valid <= (wr_ptr_n != rd_ptr_n);
            head_data  <= head_n;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/audio_adc_deserializer.sv
// rtl/audio_adc_deserializer.sv - oversampled I2S ADC receiver assembling stereo pairs into a FIFO
module audio_adc_deserializer
    import audio_adc_pkg::*;
#(
    parameter int DATA_WIDTH = ADC_DATA_WIDTH,
    parameter int FIFO_DEPTH = ADC_FIFO_DEPTH
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic                        enable,
    input  logic                        clear,
    input  logic                        adc_bclk,
    input  logic                        adc_lrck,
    input  logic                        adc_dat,
    audio_adc_deserializer_if.master    stream,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] left;
        logic [DATA_WIDTH-1:0] right;
    } pair_t;

    logic [2:0]            bclk_sync;
    logic [1:0]            lrck_sync, dat_sync;
    logic                  bclk_rise, lrck, dat;
    logic                  lrck_prev, lrck_fall, lrck_rise;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg, aligned, left_word;
    logic                  latch_left, push_now, push_valid, drop;
    pair_t                 push_pair, head;
    state_t                state, state_n;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], adc_bclk};
            lrck_sync <= {lrck_sync[0], adc_lrck};
            dat_sync  <= {dat_sync[0], adc_dat};
        end
    end

    assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
    assign lrck      = lrck_sync[1];
    assign dat       = dat_sync[1];
    assign lrck_fall = bclk_rise & lrck_prev & ~lrck;
    assign lrck_rise = bclk_rise & ~lrck_prev & lrck;
    // Short words end up left-justified; zeros fill the unreceived LSBs.
    assign aligned   = shift_reg << (CNT_MAX - bit_cnt);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (lrck_fall) state_n = LEFT;
            LEFT:    if (lrck_rise) state_n = RIGHT;
            RIGHT:   if (lrck_fall) state_n = LEFT;
            default: state_n = IDLE;
        endcase
        if (clear || !enable)
            state_n = IDLE;
    end

    always_comb begin
        latch_left = 1'b0;
        push_now   = 1'b0;
        if (enable && !clear) begin
            latch_left = (state == LEFT) && lrck_rise;
            push_now   = (state == RIGHT) && lrck_fall;
        end
    end

    // The bit at an LRCK edge is the I2S delay slot and never enters the word.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            lrck_prev  <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            left_word  <= '0;
            push_pair  <= '0;
            push_valid <= 1'b0;
        end else begin
            push_valid <= 1'b0;
            if (bclk_rise) begin
                lrck_prev <= lrck;
                if (lrck != lrck_prev) begin
                    bit_cnt   <= '0;
                    shift_reg <= '0;
                end else if (bit_cnt < CNT_MAX) begin
                    shift_reg <= {shift_reg[DATA_WIDTH-2:0], dat};
                    bit_cnt   <= bit_cnt + 1'b1;
                end
            end
            if (latch_left)
                left_word <= aligned;
            if (push_now) begin
                push_pair  <= '{left: left_word, right: aligned};
                push_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
            overflow <= 1'b0;
        else if (clear)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
    end

    audio_sample_fifo #(
        .pair_t (pair_t),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk_clk),
        .rst_n      (reset_reset_n),
        .clear      (clear),
        .push       (push_valid),
        .push_data  (push_pair),
        .pop_ready  (stream.sample_ready),
        .head_valid (stream.sample_valid),
        .head_data  (head),
        .level      (fifo_level),
        .drop       (drop)
    );

    assign stream.sample_left  = head.left;
    assign stream.sample_right = head.right;

endmodule

// File: tb/tb_audio_adc_deserializer.sv
// tb/tb_audio_adc_deserializer.sv - frame-level scoreboard bench for the I2S ADC deserializer
module tb_audio_adc_deserializer;
    import audio_adc_pkg::*;

    localparam int DW    = 24;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       clear = 1'b0;
    logic       adc_bclk = 1'b0;
    logic       adc_lrck = 1'b1;
    logic       adc_dat = 1'b0;
    logic [4:0] fifo_level;
    logic       overflow;

    audio_adc_deserializer_if #(.DATA_WIDTH(DW)) ifc ();

    audio_adc_deserializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .enable        (enable),
        .clear         (clear),
        .adc_bclk      (adc_bclk),
        .adc_lrck      (adc_lrck),
        .adc_dat       (adc_dat),
        .stream        (ifc.master),
        .fifo_level    (fifo_level),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    stereo_pair_t mq[$];
    stereo_pair_t m_pend;
    logic         m_pend_ok  = 1'b0;
    logic         m_frame_ok = 1'b0;
    logic         m_ovf      = 1'b0;
    logic         m_prev     = 1'b1;
    logic         pop_req    = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Expected word: first DW bits MSB-first, zero padded when the word is shorter.
    function automatic logic [DW-1:0] exp_word(input logic [31:0] v, input int n);
        logic [31:0] m;
        m = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        v = v & m;
        if (n >= DW) return DW'(v >> (n - DW));
        return DW'(v << (DW - n));
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("level", 64'(fifo_level), 64'(mq.size()));
            check("overflow", 64'(overflow), 64'(m_ovf));
            check("valid", 64'(ifc.sample_valid), 64'(mq.size() != 0));
            if (ifc.sample_valid && mq.size() != 0) begin
                check("head", {16'h0, ifc.sample_left, ifc.sample_right},
                      {16'h0, mq[0].left, mq[0].right});
                if (ifc.sample_ready) begin
                    void'(mq.pop_front());
                    pops++;
                end
            end
        end
    end

    // One BCLK period: LRCK/DAT change on the falling edge, capture is 8 clk later.
    task automatic send_bit(input logic l, input logic d);
        logic fall;
        fall = m_prev && !l;
        adc_bclk = 1'b0;
        adc_lrck = l;
        adc_dat  = d;
        repeat (8) @(posedge clk);
        #1;
        adc_bclk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (fall && pop_req) ifc.sample_ready = 1'b1;
        @(posedge clk);
        #1;
        if (fall) begin
            if (pop_req) ifc.sample_ready = 1'b0;
            if (m_pend_ok) begin
                if (mq.size() >= DEPTH) m_ovf = 1'b1;
                else mq.push_back(m_pend);
            end
            m_pend_ok  = 1'b0;
            m_frame_ok = 1'b1;
        end
        m_prev = l;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_half(input logic l, input logic [31:0] v, input int n);
        send_bit(l, 1'b1);
        for (int i = n - 1; i >= 0; i--) send_bit(l, v[i]);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
        send_half(1'b0, l, n);
        send_half(1'b1, r, n);
        if (m_frame_ok) begin
            m_pend.left  = exp_word(l, n);
            m_pend.right = exp_word(r, n);
            m_pend_ok    = 1'b1;
        end
    endtask

    task automatic model_flush();
        mq.delete();
        m_ovf      = 1'b0;
        m_pend_ok  = 1'b0;
        m_frame_ok = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_flush();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int cycles);
        ifc.sample_ready = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        ifc.sample_ready = 1'b0;
    endtask

    initial begin
        ifc.sample_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check("rst_valid", 64'(ifc.sample_valid), 64'd0);
        check("rst_left", 64'(ifc.sample_left), 64'd0);
        check("rst_right", 64'(ifc.sample_right), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);

        // Basic stereo frame, pushed at the second LRCK falling edge.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_frame(32'hABCDEF, 32'h123456, 24);
        check("t1_level_pre", 64'(fifo_level), 64'd0);
        send_bit(1'b0, 1'b0);
        check("t1_valid", 64'(ifc.sample_valid), 64'd1);
        check("t1_left", 64'(ifc.sample_left), 64'hABCDEF);
        check("t1_right", 64'(ifc.sample_right), 64'h123456);
        check("t1_level", 64'(fifo_level), 64'd1);
        drain(1);
        check("t1_level_pop", 64'(fifo_level), 64'd0);

        // Reset released in the middle of a right word.
        do_reset();
        send_bit(1'b1, 1'b0);
        send_half(1'b0, 32'h111111, 24);
        send_bit(1'b1, 1'b1);
        for (int i = 23; i >= 14; i--) send_bit(1'b1, 1'b1);
        do_reset();
        for (int i = 0; i < 14; i++) send_bit(1'b1, 1'b0);
        send_frame(32'h654321, 32'hFEDCBA, 24);
        send_bit(1'b0, 1'b0);
        check("t2_level", 64'(fifo_level), 64'd1);
        check("t2_pair", {16'h0, ifc.sample_left, ifc.sample_right}, 64'h654321FEDCBA);

        // Seventeen frames with no consumer: the last one is dropped.
        do_reset();
        send_bit(1'b1, 1'b0);
        for (int i = 1; i <= 17; i++)
            send_frame(32'hA00000 | i, 32'h500000 | (i << 4), 24);
        send_bit(1'b0, 1'b0);
        check("t3_level", 64'(fifo_level), 64'd16);
        check("t3_ovf", 64'(overflow), 64'd1);
        check("t3_head", {16'h0, ifc.sample_left, ifc.sample_right}, 64'hA00001500010);
        pops = 0;
        drain(20);
        check("t3_pops", 64'(pops), 64'd16);
        check("t3_level_end", 64'(fifo_level), 64'd0);
        check("t3_ovf_sticky", 64'(overflow), 64'd1);

        // Short and long words: zero fill and truncation.
        do_reset();
        send_bit(1'b1, 1'b0);
        send_frame(32'h8001, 32'h7FFE, 16);
        send_frame(32'h0ABCDEF1, 32'h01234567, 28);
        send_bit(1'b0, 1'b0);
        check("t4_level", 64'(fifo_level), 64'd2);
        check("t4_left16", 64'(ifc.sample_left), 64'h800100);
        check("t4_right16", 64'(ifc.sample_right), 64'h7FFE00);
        drain(1);
        check("t4_left28", 64'(ifc.sample_left), 64'hABCDEF);
        check("t4_right28", 64'(ifc.sample_right), 64'h123456);

        // Full FIFO with push and pop landing in the same cycle.
        do_reset();
        send_bit(1'b1, 1'b0);
        for (int i = 1; i <= 17; i++)
            send_frame(32'hA00000 | i, 32'h500000 | (i << 4), 24);
        pops = 0;
        pop_req = 1'b1;
        send_bit(1'b0, 1'b0);
        pop_req = 1'b0;
        check("t5_pops", 64'(pops), 64'd1);
        check("t5_level", 64'(fifo_level), 64'd16);
        check("t5_ovf", 64'(overflow), 64'd0);
        check("t5_head", {16'h0, ifc.sample_left, ifc.sample_right}, 64'hA00002500020);
        drain(20);
        check("t5_pops_all", 64'(pops), 64'd17);

        // Clear with level 5 and overflow set, then capture resumes.
        do_reset();
        send_bit(1'b1, 1'b0);
        for (int i = 1; i <= 17; i++)
            send_frame(32'hC00000 | i, 32'h300000 | i, 24);
        send_bit(1'b0, 1'b0);
        drain(11);
        check("t6_level5", 64'(fifo_level), 64'd5);
        check("t6_ovf1", 64'(overflow), 64'd1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_flush();
        check("t6_level0", 64'(fifo_level), 64'd0);
        check("t6_ovf0", 64'(overflow), 64'd0);
        check("t6_valid0", 64'(ifc.sample_valid), 64'd0);
        send_bit(1'b1, 1'b0);
        send_frame(32'hC0FFEE, 32'h0BEEF0, 24);
        send_bit(1'b0, 1'b0);
        check("t6_level1", 64'(fifo_level), 64'd1);
        check("t6_pair", {16'h0, ifc.sample_left, ifc.sample_right}, 64'hC0FFEE0BEEF0);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
